io_pwr_seq: RTL and testbench
=============================

IO_PWR_SEQ -- requirements
Module: io_pwr_seq

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 16: consecutive cycles both supply-good inputs must be high before sequencing, range 1..255.
REQ-002 SHALL have parameter STEP_CYC, default 4: cycles between successive release steps, range 1..255.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for asynchronous supply-good inputs, range 2..4.
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1 bit: core clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port vddio_ok, input, 1 bit: asynchronous IO-supply-good indication from the pad ring.
REQ-008 SHALL have port vdd_ok, input, 1 bit: asynchronous core-supply-good indication from the pad ring.
REQ-009 SHALL have port pwr_req, input, 1 bit: software request to bring the IO ring up (1) or down (0).
REQ-010 SHALL have port fault_clr, input, 1 bit: single-cycle pulse that clears a latched fault.
REQ-011 SHALL have port iso_n, output, 1 bit: pad isolation control, 0 = isolated.
REQ-012 SHALL have port ret_n, output, 1 bit: pad retention control, 0 = retained.
REQ-013 SHALL have port pad_en, output, 1 bit: functional pad enable.
REQ-014 SHALL have port ready, output, 1 bit: IO ring fully operational.
REQ-015 SHALL have port fault, output, 1 bit: supply lost while sequenced up, latched.
REQ-016 SHALL have port state_o, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-017 SHALL synchronize vddio_ok and vdd_ok through SYNC_STAGES flops each; supply_ok is the AND of both synchronized outputs.
REQ-018 SHALL implement states OFF=0, STABLE=1, REL_ISO=2, REL_RET=3, ON=4, DOWN=5, FAULT=6.
REQ-019 SHALL in OFF drive iso_n=0, ret_n=0, pad_en=0, ready=0, and go to STABLE when pwr_req=1 and supply_ok=1.
REQ-020 SHALL in STABLE count consecutive supply_ok cycles; it goes to REL_ISO when the count reaches STABLE_CYC, and to OFF on supply_ok=0 or pwr_req=0, which also clear the count.
REQ-021 SHALL in REL_ISO assert iso_n=1 on entry, then go to REL_RET after STEP_CYC cycles.
REQ-022 SHALL in REL_RET assert ret_n=1 on entry, then go to ON after STEP_CYC cycles.
REQ-023 SHALL in ON assert pad_en=1 and ready=1 on the same cycle as entry.
REQ-024 SHALL go from ON to DOWN on pwr_req=0; DOWN deasserts in reverse order, each step held STEP_CYC cycles: pad_en/ready to 0, then ret_n to 0, then iso_n to 0, then OFF.
REQ-025 SHALL go to FAULT on supply_ok=0 in REL_ISO, REL_RET, ON or DOWN; the same cycle drives iso_n=0, ret_n=0, pad_en=0, ready=0 and sets fault=1.
REQ-026 SHALL hold FAULT until fault_clr=1 and supply_ok=1, then clear fault and go to OFF; fault_clr with supply_ok=0 is ignored.
REQ-027 SHALL ignore pwr_req=1 during DOWN, complete the power-down and re-evaluate in OFF.
REQ-028 SHALL restart the REL_ISO or REL_RET step timer on each state entry; the timer saturates and never wraps.
REQ-029 SHALL give supply loss priority over pwr_req and over timer expiry when they occur in the same cycle.
REQ-030 SHALL keep all outputs registered, with no combinational path from any input to any output.

Reset
REQ-031 SHALL on rst_n=0 at a clock edge set state OFF, clear counters and synchronizers, and drive iso_n=0, ret_n=0, pad_en=0, ready=0, fault=0, state_o=0.
REQ-032 SHALL treat reset mid-sequence (any state, including FAULT) as immediate return to OFF with all outputs at reset values on the next edge.

Verification
REQ-033 SHALL be verified for power-up: defaults, supplies high, pwr_req=1 -> ready=1 exactly 2+16+4+4 cycles after pwr_req (±1 for sync) with iso_n rising before ret_n.
REQ-034 SHALL be verified for glitch rejection: vdd_ok low for 1 cycle at STABLE count 10 -> count restarts, no iso_n release until 16 further good cycles.
REQ-035 SHALL be verified for supply loss: vddio_ok=0 in ON -> after sync delay fault=1 and iso_n=ret_n=pad_en=ready=0; fault_clr while vddio_ok=0 leaves fault=1.
REQ-036 SHALL be verified for power-down: pwr_req=0 in ON -> pad_en=0, then ret_n=0 4 cycles later, iso_n=0 4 cycles after that, state_o=0.
REQ-037 SHALL be verified for reset mid-sequence: rst_n=0 during REL_RET -> all outputs at reset values next edge and state_o=0.
REQ-038 SHALL be verified for simultaneous events: pwr_req=0 and supply loss in the same ON cycle -> FAULT, not DOWN.

Source files
------------

// File: rtl/io_pwr_seq.sv
// io_pwr_seq: IO pad-ring power sequencer (isolation/retention/enable ordering with supply-loss fault latch)
//   clk       : core clock, all state updates on rising edge
//   rst_n     : synchronous active-low reset
//   vddio_ok  : asynchronous IO-supply-good from pad ring
//   vdd_ok    : asynchronous core-supply-good from pad ring
//   pwr_req   : request IO ring up (1) or down (0)
//   fault_clr : single-cycle pulse clearing a latched fault
//   iso_n     : pad isolation, 0 = isolated
//   ret_n     : pad retention, 0 = retained
//   pad_en    : functional pad enable
//   ready     : IO ring fully operational
//   fault     : supply lost while sequenced up (latched)
//   state_o   : current FSM state, for debug
module io_pwr_seq #(
   parameter int STABLE_CYC  = 16,
   parameter int STEP_CYC    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vddio_ok,
   input  logic       vdd_ok,
   input  logic       pwr_req,
   input  logic       fault_clr,
   output logic       iso_n,
   output logic       ret_n,
   output logic       pad_en,
   output logic       ready,
   output logic       fault,
   output logic [2:0] state_o
);
   typedef enum logic [2:0] {
      OFF     = 3'd0,
      STABLE  = 3'd1,
      REL_ISO = 3'd2,
      REL_RET = 3'd3,
      ON      = 3'd4,
      DOWN    = 3'd5,
      FAULT   = 3'd6
   } state_t;
   localparam logic [7:0] STABLE_W = STABLE_CYC[7:0];
   localparam logic [7:0] STEP_W   = STEP_CYC[7:0];
   state_t                 state_q, state_d;
   logic [7:0]             cnt_q, cnt_d, cnt_inc;
   logic [SYNC_STAGES-1:0] vddio_sync_q, vddio_sync_d, vdd_sync_q, vdd_sync_d;
   logic                   iso_n_q, iso_n_d, ret_n_q, ret_n_d, pad_en_q, pad_en_d;
   logic                   ready_q, ready_d, fault_q, fault_d;
   logic                   supply_ok, step_done, lose;
   assign vddio_sync_d = {vddio_sync_q[SYNC_STAGES-2:0], vddio_ok};
   assign vdd_sync_d   = {vdd_sync_q[SYNC_STAGES-2:0], vdd_ok};
   assign supply_ok    = vddio_sync_q[SYNC_STAGES-1] & vdd_sync_q[SYNC_STAGES-1];
   // Saturating increment: the timer must never wrap back to a live compare value
   assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
   assign step_done = (cnt_inc == STEP_W);
   // Supply loss once any pad control has been released beats every other transition
   assign lose = !supply_ok && (state_q == REL_ISO || state_q == REL_RET ||
                                state_q == ON || state_q == DOWN);
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_inc;
      iso_n_d  = iso_n_q;
      ret_n_d  = ret_n_q;
      pad_en_d = pad_en_q;
      ready_d  = ready_q;
      fault_d  = fault_q;
      unique case (state_q)
         OFF: begin
            cnt_d    = 8'd0;
            iso_n_d  = 1'b0;
            ret_n_d  = 1'b0;
            pad_en_d = 1'b0;
            ready_d  = 1'b0;
            state_d  = (pwr_req && supply_ok) ? STABLE : OFF;
         end
         STABLE: begin
            if (!supply_ok || !pwr_req) begin
               state_d = OFF;
               cnt_d   = 8'd0;
            end else if (cnt_inc == STABLE_W) begin
               state_d = REL_ISO;
               cnt_d   = 8'd0;
               iso_n_d = 1'b1;
            end
         end
         REL_ISO: begin
            if (step_done) begin
               state_d = REL_RET;
               cnt_d   = 8'd0;
               ret_n_d = 1'b1;
            end
         end
         REL_RET: begin
            if (step_done) begin
               state_d  = ON;
               cnt_d    = 8'd0;
               pad_en_d = 1'b1;
               ready_d  = 1'b1;
            end
         end
         ON: begin
            cnt_d = 8'd0;
            if (!pwr_req) begin
               state_d  = DOWN;
               pad_en_d = 1'b0;
               ready_d  = 1'b0;
            end
         end
         DOWN: begin
            // Two timed phases: retention drops first, then isolation closes and we are OFF
            if (step_done) begin
               cnt_d = 8'd0;
               if (ret_n_q) begin
                  ret_n_d = 1'b0;
               end else begin
                  iso_n_d = 1'b0;
                  state_d = OFF;
               end
            end
         end
         FAULT: begin
            cnt_d = 8'd0;
            if (fault_clr && supply_ok) begin
               fault_d = 1'b0;
               state_d = OFF;
            end
         end
         default: begin
            state_d = OFF;
            cnt_d   = 8'd0;
         end
      endcase
      if (lose) begin
         state_d  = FAULT;
         cnt_d    = 8'd0;
         iso_n_d  = 1'b0;
         ret_n_d  = 1'b0;
         pad_en_d = 1'b0;
         ready_d  = 1'b0;
         fault_d  = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= OFF;
         cnt_q        <= 8'd0;
         vddio_sync_q <= '0;
         vdd_sync_q   <= '0;
         iso_n_q      <= 1'b0;
         ret_n_q      <= 1'b0;
         pad_en_q     <= 1'b0;
         ready_q      <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         vddio_sync_q <= vddio_sync_d;
         vdd_sync_q   <= vdd_sync_d;
         iso_n_q      <= iso_n_d;
         ret_n_q      <= ret_n_d;
         pad_en_q     <= pad_en_d;
         ready_q      <= ready_d;
         fault_q      <= fault_d;
      end
   end
   assign iso_n   = iso_n_q;
   assign ret_n   = ret_n_q;
   assign pad_en  = pad_en_q;
   assign ready   = ready_q;
   assign fault   = fault_q;
   assign state_o = state_q;
endmodule

// File: tb/tb_io_pwr_seq.sv
// tb_io_pwr_seq: self-checking bench for io_pwr_seq using an event-timeline reference model
module tb_io_pwr_seq;
   localparam int SC = 16;
   localparam int ST = 4;
   localparam int S  = 2;
   logic       clk = 1'b0;
   logic       rst_n, vddio_ok, vdd_ok, pwr_req, fault_clr;
   logic       iso_n, ret_n, pad_en, ready, fault;
   logic [2:0] state_o;
   int         checks = 0;
   int         failures = 0;
   io_pwr_seq #(.STABLE_CYC(SC), .STEP_CYC(ST), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .vddio_ok(vddio_ok), .vdd_ok(vdd_ok),
      .pwr_req(pwr_req), .fault_clr(fault_clr), .iso_n(iso_n), .ret_n(ret_n),
      .pad_en(pad_en), .ready(ready), .fault(fault), .state_o(state_o)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // Expected output vector {iso_n, ret_n, pad_en, ready, fault, state_o}
   function automatic logic [7:0] ex(input bit iso, input bit ret, input bit pad, input bit flt, input int st);
      return {iso, ret, pad, pad, flt, 3'(st)};
   endfunction
   task automatic chk(input string tag, input int k, input logic [7:0] exp);
      logic [7:0] obs;
      obs = {iso_n, ret_n, pad_en, ready, fault, state_o};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
      end
   endtask
   // Power-up from OFF; gm>0 makes the FSM see a one-cycle vdd_ok dropout at edge gm.
   // A supply change driven before edge j is visible to the sequencer at edge j+S.
   task automatic pwr_up(input int gm, input int stop_k);
      int e_st, t_iso, t_ret, t_on, last, st;
      e_st  = (gm > 0) ? gm + 1 : 1;
      t_iso = e_st + SC;
      t_ret = t_iso + ST;
      t_on  = t_ret + ST;
      last  = (stop_k > 0) ? stop_k : t_on;
      pwr_req = 1'b1;
      for (int k = 1; k <= last; k++) begin
         vdd_ok = !(gm > 0 && k == gm - S);
         tick();
         st = (k >= t_on) ? 4 : (k >= t_ret) ? 3 : (k >= t_iso) ? 2 : (gm > 0 && k == gm) ? 0 : 1;
         chk(gm > 0 ? "pwr_up_glitch" : "pwr_up", k, ex(k >= t_iso, k >= t_ret, k >= t_on, 1'b0, st));
      end
      vdd_ok = 1'b1;
   endtask
   task automatic dwell(input int n);
      for (int k = 1; k <= n; k++) begin
         tick();
         chk("on_dwell", k, ex(1, 1, 1, 0, 4));
      end
   endtask
   // Power-down from ON; re=1 re-requests power during DOWN, which must wait until OFF
   task automatic pwr_down(input bit re);
      int st;
      for (int k = 1; k <= 1 + 2 * ST + (re ? 1 : 0); k++) begin
         pwr_req = re && k >= 2;
         tick();
         st = (k >= 1 + 2 * ST) ? ((re && k == 2 + 2 * ST) ? 1 : 0) : 5;
         chk("pwr_down", k, ex(k < 1 + 2 * ST, k < 1 + ST, 0, 0, st));
      end
      if (re) begin
         pwr_req = 1'b0;
         tick();
         chk("down_reeval_off", 0, ex(0, 0, 0, 0, 0));
      end
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      chk("reset_mid", 1, ex(0, 0, 0, 0, 0));
      rst_n = 1'b1;
      vdd_ok = 1'b1;
      vddio_ok = 1'b1;
      pwr_req = 1'b0;
      fault_clr = 1'b0;
      repeat (S + 1) tick();
      chk("post_reset_off", 0, ex(0, 0, 0, 0, 0));
   endtask
   // Supply loss in ON; sim=1 drops pwr_req on the very edge the loss becomes visible
   task automatic loss(input bit sim, input bit use_rst);
      bit which;
      which = 1'($urandom_range(0, 1));
      for (int k = 1; k <= S + 3; k++) begin
         if (which) vddio_ok = 1'b0;
         else vdd_ok = 1'b0;
         if (sim && k == S + 1) pwr_req = 1'b0;
         fault_clr = (k == S + 3);
         tick();
         chk(sim ? "sim_loss" : "loss", k, (k >= 1 + S) ? ex(0, 0, 0, 1, 6) : ex(1, 1, 1, 0, 4));
      end
      fault_clr = 1'b0;
      pwr_req = 1'b0;
      if (use_rst) do_reset();
      else begin
         vddio_ok = 1'b1;
         vdd_ok = 1'b1;
         for (int k = 1; k <= S + 2; k++) begin
            fault_clr = (k == S || k == S + 1);
            tick();
            chk("fault_clr", k, (k >= S + 1) ? ex(0, 0, 0, 0, 0) : ex(0, 0, 0, 1, 6));
         end
         fault_clr = 1'b0;
      end
   endtask
   initial begin
      rst_n = 1'b0;
      vddio_ok = 1'($urandom_range(0, 1));
      vdd_ok = 1'($urandom_range(0, 1));
      pwr_req = 1'($urandom_range(0, 1));
      fault_clr = 1'b0;
      repeat (3) tick();
      chk("reset_state", 0, ex(0, 0, 0, 0, 0));
      rst_n = 1'b1;
      vddio_ok = 1'b1;
      vdd_ok = 1'b1;
      pwr_req = 1'b0;
      repeat (S + 1 + $urandom_range(0, 5)) tick();
      chk("idle_off", 0, ex(0, 0, 0, 0, 0));
      pwr_up(0, 0);
      dwell($urandom_range(1, 8));
      pwr_down(0);
      pwr_up(12, 0);
      pwr_down(1);
      pwr_up(0, 0);
      loss(0, 0);
      pwr_up(0, 0);
      loss(1, 1);
      pwr_up(0, 1 + SC + ST + $urandom_range(0, ST - 1));
      do_reset();
      for (int r = 0; r < 6; r++) begin
         pwr_up($urandom_range(0, 1) ? $urandom_range(S + 1, SC + 1) : 0, 0);
         dwell($urandom_range(0, 6));
         case ($urandom_range(0, 3))
            0: pwr_down(0);
            1: pwr_down(1);
            2: loss(1'($urandom_range(0, 1)), 1'b0);
            default: loss(1'b1, 1'b1);
         endcase
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
